// File: rtl/axil_cfg_master.sv
// AXI-Lite single-outstanding configuration master: turns a simple command/response
// handshake into AW/W/B or AR/R transactions, with an optional response-wait timeout.
module axil_cfg_master #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic                      rsp_timeout,
  output logic                      awvalid,
  input  logic                      awready,
  output logic [ADDR_WIDTH-1:0]     awaddr,
  output logic                      wvalid,
  input  logic                      wready,
  output logic [DATA_WIDTH-1:0]     wdata,
  output logic [DATA_WIDTH/8-1:0]   wstrb,
  input  logic                      bvalid,
  output logic                      bready,
  input  logic [1:0]                bresp,
  output logic                      arvalid,
  input  logic                      arready,
  output logic [ADDR_WIDTH-1:0]     araddr,
  input  logic                      rvalid,
  output logic                      rready,
  input  logic [DATA_WIDTH-1:0]     rdata,
  input  logic [1:0]                rresp
);

  localparam int unsigned CNT_W   = 16;
  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0)     ? 0 :
                                    (TIMEOUT_CYCLES > 65536)  ? 65535 : TIMEOUT_CYCLES - 1;

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RSP, RD_REQ, RD_RSP, RSP, DRAIN} state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             is_write;
  logic             expire;

  // Expiry only matters when the slave response has not shown up this cycle.
  assign expire = TO_EN && (wait_cnt == CNT_W'(TO_LAST));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      is_write    <= 1'b0;
      cmd_ready   <= 1'b0;
      awvalid     <= 1'b0;
      wvalid      <= 1'b0;
      bready      <= 1'b0;
      arvalid     <= 1'b0;
      rready      <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_resp    <= '0;
      rsp_timeout <= 1'b0;
      awaddr      <= '0;
      wdata       <= '0;
      wstrb       <= '0;
      araddr      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            is_write  <= cmd_write;
            if (cmd_write) begin
              awaddr  <= cmd_addr;
              wdata   <= cmd_wdata;
              wstrb   <= cmd_wstrb;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state   <= WR_REQ;
            end else begin
              araddr  <= cmd_addr;
              arvalid <= 1'b1;
              state   <= RD_REQ;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        WR_REQ: begin
          if (awready) awvalid <= 1'b0;
          if (wready)  wvalid  <= 1'b0;
          if ((!awvalid || awready) && (!wvalid || wready)) begin
            bready   <= 1'b1;
            wait_cnt <= '0;
            state    <= WR_RSP;
          end
        end
        RD_REQ: begin
          if (arready) begin
            arvalid  <= 1'b0;
            rready   <= 1'b1;
            wait_cnt <= '0;
            state    <= RD_RSP;
          end
        end
        WR_RSP, RD_RSP: begin
          if ((state == WR_RSP) ? bvalid : rvalid) begin
            bready      <= 1'b0;
            rready      <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_resp    <= (state == WR_RSP) ? bresp : rresp;
            rsp_rdata   <= (state == WR_RSP) ? '0 : rdata;
            rsp_timeout <= 1'b0;
            state       <= RSP;
          end else if (expire) begin
            // Readies drop while the timeout response is pending; DRAIN re-raises them.
            bready      <= 1'b0;
            rready      <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_resp    <= 2'b10;
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b1;
            state       <= RSP;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (rsp_timeout) begin
              bready <= is_write;
              rready <= !is_write;
              state  <= DRAIN;
            end else begin
              cmd_ready <= 1'b1;
              state     <= IDLE;
            end
          end
        end
        DRAIN: begin
          if ((bready && bvalid) || (rready && rvalid)) begin
            bready    <= 1'b0;
            rready    <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_cfg_master.sv
// Self-checking bench for axil_cfg_master: directed AXI-Lite slave behaviour per test,
// expected responses queued at command time and compared when the response is consumed.
module tb_axil_cfg_master;

  localparam int unsigned AW = 32;
  localparam int unsigned TO = 8;

  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        timeout;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [31:0]   cmd_wdata;
  logic [3:0]    cmd_wstrb;
  logic          rsp_valid, rsp_ready;
  logic [31:0]   rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          rsp_timeout;
  logic          awvalid, awready;
  logic [AW-1:0] awaddr;
  logic          wvalid, wready;
  logic [31:0]   wdata;
  logic [3:0]    wstrb;
  logic          bvalid, bready;
  logic [1:0]    bresp;
  logic          arvalid, arready;
  logic [AW-1:0] araddr;
  logic          rvalid, rready;
  logic [31:0]   rdata;
  logic [1:0]    rresp;

  int   n_checks = 0;
  int   n_fail   = 0;
  rsp_t exp_q[$];

  axil_cfg_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  // Present a command at a negedge and return at the negedge after it is accepted.
  task automatic send_cmd(input logic wr, input logic [AW-1:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    int b = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    while (cmd_ready !== 1'b1 && b < 20) begin
      @(negedge clk);
      b++;
    end
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL cmd_accept cmd_ready=%b required 1", cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Wait for a response, optionally stall it, then compare against the scoreboard.
  task automatic consume_rsp(input string tag, input int hold);
    rsp_t got, exp;
    int   b = 0;
    while (rsp_valid !== 1'b1 && b < 40) begin
      @(negedge clk);
      b++;
    end
    n_checks++;
    if (rsp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_rsp_valid got %b required 1", tag, rsp_valid);
      return;
    end
    got = {rsp_rdata, rsp_resp, rsp_timeout};
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b1 || {rsp_rdata, rsp_resp, rsp_timeout} !== got) begin
        n_fail++;
        $display("FAIL %s_hold%0d valid=%b data=%h required valid=1 data=%h", tag, i,
                 rsp_valid, {rsp_rdata, rsp_resp, rsp_timeout}, got);
      end
    end
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s_scoreboard unexpected response %h", tag, got);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        n_fail++;
        $display("FAIL %s_payload rdata=%h resp=%b timeout=%b required rdata=%h resp=%b timeout=%b",
                 tag, got.rdata, got.resp, got.timeout, exp.rdata, exp.resp, exp.timeout);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_rsp_drop rsp_valid=%b required 0", tag, rsp_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid} !== 7'b0 ||
        rsp_rdata !== 32'h0 || rsp_resp !== 2'b00 || rsp_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs ctl=%b rdata=%h resp=%b to=%b required all zero",
               {cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid},
               rsp_rdata, rsp_resp, rsp_timeout);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release cmd_ready=%b required 1", cmd_ready);
    end
  endtask

  task automatic test_write_aw_first();
    send_cmd(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    exp_q.push_back('{rdata: 32'h0, resp: 2'b00, timeout: 1'b0});
    n_checks++;
    if ({awvalid, wvalid} !== 2'b11 || awaddr !== 32'h10 || wdata !== 32'hDEADBEEF ||
        wstrb !== 4'hF) begin
      n_fail++;
      $display("FAIL wr_req valids=%b addr=%h data=%h strb=%h required 11 10 deadbeef f",
               {awvalid, wvalid}, awaddr, wdata, wstrb);
    end
    awready = 1'b1;
    @(negedge clk);
    awready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if ({awvalid, wvalid} !== 2'b01 || wdata !== 32'hDEADBEEF) begin
        n_fail++;
        $display("FAIL wr_aw_done%0d valids=%b wdata=%h required 01 deadbeef", i,
                 {awvalid, wvalid}, wdata);
      end
      if (i == 1) wready = 1'b1;
      @(negedge clk);
    end
    wready = 1'b0;
    n_checks++;
    if ({awvalid, wvalid, bready} !== 3'b001) begin
      n_fail++;
      $display("FAIL wr_rsp_entry aw/w/bready=%b required 001", {awvalid, wvalid, bready});
    end
    bvalid = 1'b1; bresp = 2'b00;
    @(negedge clk);
    bvalid = 1'b0;
    consume_rsp("write_aw_first", 0);
  endtask

  task automatic test_read_slow();
    send_cmd(1'b0, 32'h14, 32'h0, 4'h0);
    exp_q.push_back('{rdata: 32'hC0000001, resp: 2'b00, timeout: 1'b0});
    @(negedge clk);
    n_checks++;
    if (arvalid !== 1'b1 || araddr !== 32'h14) begin
      n_fail++;
      $display("FAIL rd_req arvalid=%b araddr=%h required 1 14", arvalid, araddr);
    end
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (rready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_wait rready=%b rsp_valid=%b required 1 0", rready, rsp_valid);
    end
    rvalid = 1'b1; rdata = 32'hC0000001; rresp = 2'b00;
    @(negedge clk);
    rvalid = 1'b0;
    consume_rsp("read_slow", 3);
  endtask

  task automatic test_write_same_cycle_slverr();
    send_cmd(1'b1, 32'h20, 32'h12345678, 4'h3);
    exp_q.push_back('{rdata: 32'h0, resp: 2'b10, timeout: 1'b0});
    awready = 1'b1; wready = 1'b1;
    @(negedge clk);
    awready = 1'b0; wready = 1'b0;
    n_checks++;
    if ({awvalid, wvalid, bready} !== 3'b001) begin
      n_fail++;
      $display("FAIL wr_same_cycle aw/w/bready=%b required 001", {awvalid, wvalid, bready});
    end
    bvalid = 1'b1; bresp = 2'b10;
    @(negedge clk);
    bvalid = 1'b0;
    consume_rsp("write_slverr", 0);
  endtask

  task automatic test_back_to_back();
    send_cmd(1'b1, 32'h40, 32'hA5A50F0F, 4'h5);
    exp_q.push_back('{rdata: 32'h0, resp: 2'b01, timeout: 1'b0});
    wready = 1'b1;
    @(negedge clk);
    wready = 1'b0;
    n_checks++;
    if ({awvalid, wvalid} !== 2'b10 || awaddr !== 32'h40) begin
      n_fail++;
      $display("FAIL wr_w_first valids=%b awaddr=%h required 10 40", {awvalid, wvalid}, awaddr);
    end
    awready = 1'b1;
    @(negedge clk);
    awready = 1'b0;
    bvalid = 1'b1; bresp = 2'b01;
    @(negedge clk);
    bvalid = 1'b0;
    consume_rsp("b2b_write", 0);
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_cmd_ready cmd_ready=%b required 1", cmd_ready);
    end
    send_cmd(1'b0, 32'h44, 32'h0, 4'h0);
    exp_q.push_back('{rdata: 32'h5A5A1234, resp: 2'b11, timeout: 1'b0});
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    rvalid = 1'b1; rdata = 32'h5A5A1234; rresp = 2'b11;
    @(negedge clk);
    rvalid = 1'b0;
    consume_rsp("b2b_read", 1);
  endtask

  task automatic test_timeout_drain();
    send_cmd(1'b0, 32'h30, 32'h0, 4'h0);
    exp_q.push_back('{rdata: 32'h0, resp: 2'b10, timeout: 1'b1});
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    for (int i = 1; i < 9; i++) begin
      n_checks++;
      if (rsp_valid !== 1'b0 || rready !== 1'b1) begin
        n_fail++;
        $display("FAIL to_wait%0d rsp_valid=%b rready=%b required 0 1", i, rsp_valid, rready);
      end
      @(negedge clk);
    end
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL to_expire rsp_valid=%b rsp_timeout=%b required 1 1", rsp_valid, rsp_timeout);
    end
    consume_rsp("timeout", 0);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (cmd_ready !== 1'b0 || rready !== 1'b1) begin
        n_fail++;
        $display("FAIL drain%0d cmd_ready=%b rready=%b required 0 1", i, cmd_ready, rready);
      end
      @(negedge clk);
    end
    rvalid = 1'b1; rdata = 32'hBAD0BAD0; rresp = 2'b00;
    @(negedge clk);
    rvalid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b1 || rready !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_exit cmd_ready=%b rready=%b rsp_valid=%b required 1 0 0",
               cmd_ready, rready, rsp_valid);
    end
  endtask

  task automatic test_timeout_race();
    send_cmd(1'b0, 32'h34, 32'h0, 4'h0);
    exp_q.push_back('{rdata: 32'h0000BEEF, resp: 2'b00, timeout: 1'b0});
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    repeat (7) @(negedge clk);
    rvalid = 1'b1; rdata = 32'h0000BEEF; rresp = 2'b00;
    @(negedge clk);
    rvalid = 1'b0;
    consume_rsp("timeout_race", 0);
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL race_idle cmd_ready=%b required 1", cmd_ready);
    end
  endtask

  task automatic test_reset_mid_txn();
    send_cmd(1'b1, 32'h50, 32'h11112222, 4'hF);
    awready = 1'b1; wready = 1'b1;
    @(negedge clk);
    awready = 1'b0; wready = 1'b0;
    n_checks++;
    if (bready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_bready bready=%b required 1", bready);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({cmd_ready, bready, rsp_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_mid_held cmd_ready/bready/rsp_valid=%b required 000",
               {cmd_ready, bready, rsp_valid});
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_release cmd_ready=%b rsp_valid=%b required 1 0", cmd_ready, rsp_valid);
    end
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b0;
    awready = 1'b0; wready = 1'b0; arready = 1'b0;
    bvalid = 1'b0; bresp = 2'b00; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
    @(negedge clk);
    test_reset();
    test_write_aw_first();
    test_read_slow();
    test_write_same_cycle_slverr();
    test_back_to_back();
    test_timeout_drain();
    test_timeout_race();
    test_reset_mid_txn();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty pending=%0d required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
